// File: rtl/rv_decode_pkg.sv
// Shared decode constants for the RV32IM decode stage.
// Combinational helpers only; no state lives here.
// Holds opcodes, the immediate-format enum and the legal OP funct7 set.
package rv_decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_ENC    = 7'b0001011;

    // funct7 values accepted on the OP opcode: base ALU, SUB/SRA, M-extension.
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_t;

    // Opcode to immediate format; OP, ENC and unknown opcodes carry no immediate.
    function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opc);
        imm_fmt_t fmt;
        case (opc)
            OPC_LOAD, OPC_JALR, OPC_OP_IMM: fmt = IMM_I;
            OPC_STORE:                      fmt = IMM_S;
            OPC_BRANCH:                     fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
            OPC_JAL:                        fmt = IMM_J;
            default:                        fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    function automatic logic opcode_known(input logic [6:0] opc);
        logic known;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_ENC: known = 1'b1;
            default:                                          known = 1'b0;
        endcase
        return known;
    endfunction

    function automatic logic op_funct7_legal(input logic [6:0] f7);
        return (f7 == F7_BASE) || (f7 == F7_ALT) || (f7 == F7_MULDIV);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks the RV32 format from the opcode and sign-extends.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows instr directly.
// Ports: instr (32b instruction word) -> imm (32b sign-extended immediate).
module imm_gen
    import rv_decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    imm_fmt_t fmt;

    assign fmt = imm_fmt_of(instr[6:0]);

    always_comb begin
        imm = 32'h0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32IM decode stage with a custom-0 encryption interlock.
// Latency: one cycle, accept at edge N and the decoded entry is valid after N; 1/cycle throughput.
// Backpressure: in_ready drops on flush, on a held entry not being consumed, or on ENC while busy.
// Ports: fetch side in_valid/in_ready/in_pc/in_instr; control flush, enc_done;
//        ID/EX side out_valid/out_ready plus registered decode fields out_*; enc_busy status.
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int ADDRESS_BITS = 16,
    parameter int ENC_CYCLES   = 8,
    parameter int CNT_W        = $clog2(ENC_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDRESS_BITS-1:0] in_pc,
    input  logic [31:0]             in_instr,
    input  logic                    flush,
    input  logic                    enc_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDRESS_BITS-1:0] out_pc,
    output logic [6:0]              out_op,
    output logic [2:0]              out_funct3,
    output logic [6:0]              out_funct7,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [4:0]              out_rd,
    output logic [31:0]             out_imm,
    output logic [ADDRESS_BITS-1:0] out_target,
    output logic                    out_wen,
    output logic                    out_en,
    output logic                    out_illegal,
    output logic                    out_is_enc,
    output logic                    enc_busy
);

    logic [6:0]              opc;
    logic [6:0]              f7;
    logic [31:0]             imm;
    logic                    in_is_enc;
    logic                    in_illegal;
    logic                    in_wen;
    logic                    in_en;
    logic [ADDRESS_BITS-1:0] in_target;
    logic                    accept;
    logic [CNT_W-1:0]        enc_cnt;

    assign opc = in_instr[6:0];
    assign f7  = in_instr[31:25];

    imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (imm)
    );

    assign in_is_enc  = (opc == OPC_ENC);
    assign in_illegal = !opcode_known(opc) || ((opc == OPC_OP) && !op_funct7_legal(f7));

    // Only JAL and BRANCH have a PC-relative target; the adder wraps at the PC width.
    assign in_target = ((opc == OPC_JAL) || (opc == OPC_BRANCH))
                     ? (in_pc + imm[ADDRESS_BITS-1:0])
                     : '0;

    assign in_wen = !((opc == OPC_STORE) || (opc == OPC_BRANCH) || in_is_enc ||
                      in_illegal || (in_instr[11:7] == 5'd0));
    assign in_en  = !(in_is_enc || in_illegal);

    assign enc_busy = (enc_cnt != '0);

    // Only a second ENC is held off by the accelerator; other instructions flow past it.
    assign in_ready = !flush && (!out_valid || out_ready) && !(enc_busy && in_is_enc);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pc      <= '0;
            out_op      <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_imm     <= '0;
            out_target  <= '0;
            out_wen     <= 1'b0;
            out_en      <= 1'b0;
            out_illegal <= 1'b0;
            out_is_enc  <= 1'b0;
        end else if (accept) begin
            out_pc      <= in_pc;
            out_op      <= opc;
            out_funct3  <= in_instr[14:12];
            out_funct7  <= f7;
            out_rs1     <= in_instr[19:15];
            out_rs2     <= in_instr[24:20];
            out_rd      <= in_instr[11:7];
            out_imm     <= imm;
            out_target  <= in_target;
            out_wen     <= in_wen;
            out_en      <= in_en;
            out_illegal <= in_illegal;
            out_is_enc  <= in_is_enc;
        end
    end

    // Busy counter ignores flush: the accelerator is already running once an ENC issues.
    // A fresh ENC load takes priority over an early-completion clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_cnt <= '0;
        end else if (accept && in_is_enc) begin
            enc_cnt <= CNT_W'(ENC_CYCLES);
        end else if (enc_done) begin
            enc_cnt <= '0;
        end else if (enc_cnt != '0) begin
            enc_cnt <= enc_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    localparam int AB = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AB-1:0] in_pc;
    logic [31:0]   in_instr;
    logic          flush;
    logic          enc_done;
    logic          out_valid;
    logic          out_ready;
    logic [AB-1:0] out_pc;
    logic [6:0]    out_op;
    logic [2:0]    out_funct3;
    logic [6:0]    out_funct7;
    logic [4:0]    out_rs1;
    logic [4:0]    out_rs2;
    logic [4:0]    out_rd;
    logic [31:0]   out_imm;
    logic [AB-1:0] out_target;
    logic          out_wen;
    logic          out_en;
    logic          out_illegal;
    logic          out_is_enc;
    logic          enc_busy;

    always #5 clk = ~clk;

    decode_stage #(.ADDRESS_BITS(AB), .ENC_CYCLES(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .flush       (flush),
        .enc_done    (enc_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_op      (out_op),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_imm     (out_imm),
        .out_target  (out_target),
        .out_wen     (out_wen),
        .out_en      (out_en),
        .out_illegal (out_illegal),
        .out_is_enc  (out_is_enc),
        .enc_busy    (enc_busy)
    );

    typedef struct {
        logic [AB-1:0] pc;
        logic [31:0]   instr;
        logic [31:0]   imm;
        logic [AB-1:0] tgt;
        logic          wen;
        logic          en;
        logic          ill;
        logic          enc;
    } exp_t;

    exp_t vt[12];
    exp_t sb[$];
    int   cur = 0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setv(input int i, input logic [AB-1:0] pc, input logic [31:0] instr,
                        input logic [31:0] imm, input logic [AB-1:0] tgt,
                        input logic wen, input logic en, input logic ill, input logic enc);
        vt[i].pc    = pc;
        vt[i].instr = instr;
        vt[i].imm   = imm;
        vt[i].tgt   = tgt;
        vt[i].wen   = wen;
        vt[i].en    = en;
        vt[i].ill   = ill;
        vt[i].enc   = enc;
    endtask

    task automatic check_out(input exp_t e);
        logic [31:0] w;
        w = e.instr;
        check("valid",   32'(out_valid),   32'd1);
        check("pc",      32'(out_pc),      32'(e.pc));
        check("op",      32'(out_op),      32'(w[6:0]));
        check("funct3",  32'(out_funct3),  32'(w[14:12]));
        check("funct7",  32'(out_funct7),  32'(w[31:25]));
        check("rs1",     32'(out_rs1),     32'(w[19:15]));
        check("rs2",     32'(out_rs2),     32'(w[24:20]));
        check("rd",      32'(out_rd),      32'(w[11:7]));
        check("imm",     out_imm,          e.imm);
        check("target",  32'(out_target),  32'(e.tgt));
        check("wen",     32'(out_wen),     32'(e.wen));
        check("en",      32'(out_en),      32'(e.en));
        check("illegal", 32'(out_illegal), 32'(e.ill));
        check("is_enc",  32'(out_is_enc),  32'(e.enc));
    endtask

    // One clock: sample handshake before the edge, score the new entry after it.
    task automatic cycle(output bit acc);
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        if (acc) sb.push_back(vt[cur]);
        @(posedge clk);
        #1;
        if (acc) begin
            e = sb.pop_front();
            check_out(e);
            check("sb_left", 32'(sb.size()), 32'd0);
        end
    endtask

    task automatic drive(input int idx);
        cur      = idx;
        in_valid = 1'b1;
        in_pc    = vt[idx].pc;
        in_instr = vt[idx].instr;
    endtask

    task automatic send(input int idx, input int budget, output int stalls);
        bit acc;
        acc    = 1'b0;
        stalls = 0;
        drive(idx);
        for (int k = 0; k <= budget && !acc; k++) begin
            cycle(acc);
            if (!acc) stalls++;
        end
        check("accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle_busy(input int budget);
        bit acc;
        for (int k = 0; k < budget && enc_busy; k++) cycle(acc);
        check("busy_drained", 32'(enc_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        bit acc;

        setv(0,  16'h0100, 32'hFFF00293, 32'hFFFFFFFF, 16'h0000, 1, 1, 0, 0); // addi x5,x0,-1
        setv(1,  16'hFFF0, 32'h001000EF, 32'h00000800, 16'h07F0, 1, 1, 0, 0); // jal x1,+2048
        setv(2,  16'h0104, 32'hFE21AE23, 32'hFFFFFFFC, 16'h0000, 0, 1, 0, 0); // sw x2,-4(x3)
        setv(3,  16'h0108, 32'h00001037, 32'h00001000, 16'h0000, 0, 1, 0, 0); // lui x0,1
        setv(4,  16'h0010, 32'hFE208CE3, 32'hFFFFFFF8, 16'h0008, 0, 1, 0, 0); // beq x1,x2,-8
        setv(5,  16'h010C, 32'hFE0001B3, 32'h00000000, 16'h0000, 0, 0, 1, 0); // OP funct7=7F
        setv(6,  16'h0110, 32'h02208233, 32'h00000000, 16'h0000, 1, 1, 0, 0); // mul x4,x1,x2
        setv(7,  16'h0120, 32'h0000030B, 32'h00000000, 16'h0000, 0, 0, 0, 1); // ENC rd=6
        setv(8,  16'h0200, 32'h00000F7F, 32'h00000000, 16'h0000, 0, 0, 1, 0); // unknown opcode
        setv(9,  16'h0204, 32'h80000397, 32'h80000000, 16'h0000, 1, 1, 0, 0); // auipc x7
        setv(10, 16'h0208, 32'hFFF4A403, 32'hFFFFFFFF, 16'h0000, 1, 1, 0, 0); // lw x8,-1(x9)
        setv(11, 16'h0300, 32'h004100E7, 32'h00000004, 16'h0000, 1, 1, 0, 0); // jalr x1,4(x2)

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        flush     = 1'b0;
        enc_done  = 1'b0;
        out_ready = 1'b1;

        #12;
        check("rst_valid",  32'(out_valid),  32'd0);
        check("rst_busy",   32'(enc_busy),   32'd0);
        check("rst_imm",    out_imm,         32'd0);
        check("rst_pc",     32'(out_pc),     32'd0);
        check("rst_wen",    32'(out_wen),    32'd0);
        check("rst_target", 32'(out_target), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back stream with out_ready held high: no stalls expected.
        for (int i = 0; i <= 6; i++) begin
            send(i, 2, st);
            check("stream_stall", 32'(st), 32'd0);
        end
        send(11, 2, st);
        cycle(acc);
        check("drained_valid", 32'(out_valid), 32'd0);

        // Two ENC words: second waits exactly ENC_CYCLES cycles.
        send(7, 2, st);
        check("enc_busy_set", 32'(enc_busy), 32'd1);
        send(7, 10, st);
        check("enc_stall_cycles", 32'(st), 32'd3);
        wait_idle_busy(10);

        // enc_done one cycle after the first ENC releases the second on the next cycle.
        send(7, 2, st);
        drive(7);
        enc_done = 1'b1;
        cycle(acc);
        check("enc_done_stall", 32'(acc), 32'd0);
        enc_done = 1'b0;
        cycle(acc);
        check("enc_done_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        wait_idle_busy(10);

        // Backpressure: held entry stays stable, nothing new accepted.
        send(8, 2, st);
        out_ready = 1'b0;
        drive(9);
        for (int k = 0; k < 4; k++) begin
            cycle(acc);
            check("bp_accept", 32'(acc), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_pc", 32'(out_pc), 32'(vt[8].pc));
            check("bp_rd", 32'(out_rd), 32'd30);
            check("bp_illegal", 32'(out_illegal), 32'd1);
        end
        out_ready = 1'b1;
        cycle(acc);
        check("bp_resume", 32'(acc), 32'd1);
        in_valid = 1'b0;
        cycle(acc);

        // Flush with a held entry and a pending input while the accelerator is busy.
        send(7, 2, st);
        send(10, 2, st);
        check("nonenc_while_busy", 32'(st), 32'd0);
        check("busy_before_flush", 32'(enc_busy), 32'd1);
        out_ready = 1'b0;
        flush     = 1'b1;
        drive(0);
        cycle(acc);
        check("flush_accept", 32'(acc), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_busy", 32'(enc_busy), 32'd1);
        flush     = 1'b0;
        out_ready = 1'b1;
        cycle(acc);
        check("post_flush_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        wait_idle_busy(10);

        // Asynchronous reset mid-operation clears the entry and the counter at once.
        send(7, 2, st);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_busy", 32'(enc_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(enc_busy), 32'd0);
        check("arst_rd", 32'(out_rd), 32'd0);
        check("arst_is_enc", 32'(out_is_enc), 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked RV32IM decode stage: the parametrised successor to the combinational decoder. It splits a fetched instruction into register selects, opcode fields and a fully sign-extended immediate for every RV32 format, computes PC-relative targets, and flags illegal encodings. It also interlocks back-to-back custom-0 encryption instructions against a busy accelerator. It sits between fetch and the ID/EX pipeline register, with valid/ready on both sides and a flush input from branch resolution.

## Interface
- ADDRESS_BITS, 16: PC and target width.
- ENC_CYCLES, 8: cycles the accelerator stays busy after an encryption instruction issues (≥1).
- CNT_W, $clog2(ENC_CYCLES+1): busy-counter width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  ADDRESS_BITS  PC of instruction.
- in_instr  in  32  instruction word.
- flush  in  1  kill held and incoming instruction.
- enc_done  in  1  accelerator finished early; clears busy.
- out_valid  out  1  decoded entry held.
- out_ready  in  1  downstream accepts.
- out_pc  out  ADDRESS_BITS  registered PC.
- out_op  out  7  instr[6:0].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], [24:20], [11:7].
- out_imm  out  32  format-selected sign-extended immediate.
- out_target  out  ADDRESS_BITS  pc+imm for JAL/BRANCH, else 0.
- out_wen  out  1  GPR write enable.
- out_en  out  1  GPR port enable.
- out_illegal  out  1  unsupported encoding.
- out_is_enc  out  1  custom-0 encryption instruction.
- enc_busy  out  1  accelerator interlock active.

## Operation
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, ENC 0001011.
- Immediates:
  - I: sext(instr[31:20]), used by LOAD, JALR and OP-IMM.
  - S: sext({[31:25],[11:7]}).
  - B: sext({[31],[7],[30:25],[11:8],0}).
  - U: {[31:12],12'b0}, used by LUI and AUIPC.
  - J: sext({[31],[19:12],[20],[30:21],0}).
  - OP, ENC and illegal instructions: 0.
- out_target = (in_pc + imm[ADDRESS_BITS-1:0]) mod 2^ADDRESS_BITS. It wraps silently.
- Write and port enables:
  - out_wen = 0 for STORE, BRANCH, ENC, illegal, or rd==0; otherwise 1.
  - out_en = 0 for ENC and illegal; otherwise 1.
- Illegal when either:
  - the opcode is outside the list above;
  - the opcode is OP and funct7 ∉ {0000000, 0100000, 0000001}.
- Handshake:
  - An input is accepted when in_valid && in_ready. Output is consumed when out_valid && out_ready.
  - in_ready = !flush && (!out_valid || out_ready) && !(enc_busy && in_instr is ENC).
  - A non-ENC instruction proceeds while enc_busy.
- Encryption interlock counter:
  - Reset 0.
  - Loaded with ENC_CYCLES when an ENC instruction is accepted.
  - Decrements by 1 per cycle while nonzero.
  - Forced to 0 by enc_done, unless an ENC is accepted in the same cycle; the load wins.
  - enc_busy = (counter != 0).
- Flush:
  - out_valid goes 0 on the next edge and nothing is accepted that cycle.
  - The counter is unaffected, because the accelerator is already running.

## Timing
- Latency: accept at edge N, outputs valid after edge N. Full throughput of 1/cycle when out_ready is held high.
- All out_* fields are registered and update only on accept. They hold while out_valid && !out_ready.
- Reset state: every output 0, including out_valid and enc_busy. in_ready is 1 after reset.
- Simultaneous consume and accept: the entry is replaced, with no bubble.
- flush together with in_valid: the input is dropped.
- flush together with out_ready: the held entry is not delivered. Downstream must ignore it.
- Asserting rst_n mid-operation clears the held entry and the counter immediately.

## Structure
- Package rv_decode_pkg holds:
  - opcode localparams;
  - imm-format enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE};
  - the legal-funct7 constants.
- Sub-module imm_gen is combinational: instr → format → imm.
- Output register, handshake and interlock counter live in decode_stage.

## Test plan
- Reset then `addi x5,x0,-1` (0xFFF00293) → next cycle: out_rd=5, out_imm=0xFFFFFFFF, out_wen=1, out_illegal=0.
- `jal x1,+2048` at pc=0xFFF0 with ADDRESS_BITS=16 → out_target=0x07F0 (wrap), out_imm=0x00000800, out_wen=1.
- `sw x2,-4(x3)` (0xFE21AE23) → out_imm=0xFFFFFFFC, out_wen=0; `lui x0,1` → out_wen=0.
- Two consecutive ENC words, ENC_CYCLES=3:
  - first is accepted;
  - second sees in_ready=0 for 3 cycles, then is accepted;
  - repeat with enc_done pulsed one cycle after the first is accepted → second is accepted the following cycle.
- out_ready=0 for 4 cycles with in_valid=1 → out_* stable and in_ready=0; then out_ready=1 → stream resumes with no drop or duplicate.
- flush while holding an entry and in_valid=1 → out_valid=0 next cycle, the input is not accepted, and enc_busy is unchanged. OP with funct7=0x7F gives out_illegal=1, out_wen=0 and out_en=0.
